preamble_seq_gen: RTL and testbench

- Establishment-phase sequence generator, directly downstream of the control unit.
- While seq_enable is high, it transmits a preamble of seq_num alternating pattern words built from seq_data, followed by one SYNC word, over a valid/ready word link.
- It then reports seq_done back to the control unit, which moves to randomization.
- The receiver locks onto the alternating pattern plus SYNC, so transmission start is detected without an out-valid strobe.

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/preamble_word_mux.sv | 24 ++
 rtl/preamble_seq_gen.sv | 154 +++++++++++++++
 tb/tb_preamble_seq_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: state encoding and width/word defaults
// used by the control unit and the preamble sequence generator.
package ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

  localparam logic [31:0] SYNC_WORD_DEF = 32'hA5C3_3C5A;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SEND = 4'b0010,
    ST_SYNC = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

endpackage

// File: rtl/preamble_word_mux.sv
// Selects the next outgoing word for the state being entered:
// the pattern, its complement, or the SYNC terminator.
module preamble_word_mux
  import ctrl_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEF)
) (
  input  state_e            state,
  input  logic              odd,
  input  logic [DATA_W-1:0] pat,
  output logic [DATA_W-1:0] word
);

  always_comb begin
    word = '0;
    case (state)
      ST_SEND: word = odd ? ~pat : pat;
      ST_SYNC: word = SYNC_WORD;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/preamble_seq_gen.sv
// Establishment-phase preamble generator: alternating pattern words
// followed by one SYNC word over a valid/ready link.
module preamble_seq_gen
  import ctrl_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                CNT_W     = CNT_W_DEF,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seq_enable,
  input  logic [CNT_W-1:0]  seq_num,
  input  logic [DATA_W-1:0] seq_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              seq_done,
  output logic              busy
);

  state_e            state, nstate, tgt;
  logic [CNT_W-1:0]  cnt, n_cnt, num, n_num;
  logic [DATA_W-1:0] pat, n_pat, src, word, n_data;
  logic              n_valid, n_last, n_done, n_busy;
  logic              odd, xfer, last_word;

  assign xfer      = tx_valid && tx_ready;
  assign last_word = (cnt == num - CNT_W'(1));

  // Word-select inputs derive only from registered state, never nstate.
  always_comb begin
    tgt = state;
    odd = 1'b0;
    src = pat;
    case (state)
      ST_IDLE: begin
        tgt = (seq_num == '0) ? ST_SYNC : ST_SEND;
        src = seq_data;
      end
      ST_SEND: begin
        tgt = last_word ? ST_SYNC : ST_SEND;
        odd = ~cnt[0];
      end
      default: tgt = state;
    endcase
  end

  preamble_word_mux #(
    .DATA_W    (DATA_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_mux (
    .state (tgt),
    .odd   (odd),
    .pat   (src),
    .word  (word)
  );

  always_comb begin
    nstate  = state;
    n_cnt   = cnt;
    n_num   = num;
    n_pat   = pat;
    n_data  = tx_data;
    n_valid = tx_valid;
    n_last  = tx_last;
    n_done  = seq_done;
    case (state)
      ST_IDLE: begin
        n_valid = 1'b0;
        n_last  = 1'b0;
        n_done  = 1'b0;
        if (seq_enable) begin
          n_pat   = seq_data;
          n_num   = seq_num;
          n_cnt   = '0;
          nstate  = tgt;
          n_valid = 1'b1;
          n_data  = word;
          n_last  = (tgt == ST_SYNC);
        end
      end
      ST_SEND: begin
        if (!seq_enable) begin
          nstate  = ST_IDLE;
          n_valid = 1'b0;
          n_last  = 1'b0;
          n_done  = 1'b0;
        end else if (xfer) begin
          n_cnt  = cnt + CNT_W'(1);
          nstate = tgt;
          n_data = word;
          n_last = (tgt == ST_SYNC);
        end
      end
      ST_SYNC: begin
        if (!seq_enable) begin
          nstate  = ST_IDLE;
          n_valid = 1'b0;
          n_last  = 1'b0;
          n_done  = 1'b0;
        end else if (xfer) begin
          nstate  = ST_DONE;
          n_valid = 1'b0;
          n_last  = 1'b0;
          n_done  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!seq_enable) begin
          nstate = ST_IDLE;
          n_done = 1'b0;
        end
      end
      default: begin
        nstate  = ST_IDLE;
        n_cnt   = '0;
        n_num   = '0;
        n_pat   = '0;
        n_data  = '0;
        n_valid = 1'b0;
        n_last  = 1'b0;
        n_done  = 1'b0;
      end
    endcase
    n_busy = (nstate == ST_SEND) || (nstate == ST_SYNC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      num      <= '0;
      pat      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      seq_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nstate;
      cnt      <= n_cnt;
      num      <= n_num;
      pat      <= n_pat;
      tx_data  <= n_data;
      tx_valid <= n_valid;
      tx_last  <= n_last;
      seq_done <= n_done;
      busy     <= n_busy;
    end
  end

endmodule

// File: tb/tb_preamble_seq_gen.sv
// Self-checking bench for preamble_seq_gen: vector table of runs plus
// hand-written abort and async-reset sequences, scoreboarded per transfer.
module tb_preamble_seq_gen;

  localparam logic [31:0] SYNC = 32'hA5C3_3C5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seq_enable = 1'b0;
  logic [7:0]  seq_num = '0;
  logic [31:0] seq_data = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        seq_done;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int xfers = 0;

  logic [32:0] sbq[$];
  logic [32:0] e;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_en = 1'b0;
  logic        prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic        exp_done = 1'b0;

  typedef struct {
    logic [7:0]  num;
    logic [31:0] data;
    logic [15:0] rpat;
    int          exp_xfers;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  preamble_seq_gen dut (
    .clk        (clk),
    .rst        (rst),
    .seq_enable (seq_enable),
    .seq_num    (seq_num),
    .seq_data   (seq_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .seq_done   (seq_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [7:0] n, input logic [31:0] d);
    for (int k = 0; k < int'(n); k++)
      sbq.push_back({1'b0, k[0] ? ~d : d});
    sbq.push_back({1'b1, SYNC});
  endtask

  // Monitor: transfers, hold-under-backpressure and done timing.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && prev_en) begin
        chk("hold_valid", 64'(tx_valid), 64'd1);
        chk("hold_word", 64'({tx_last, tx_data}), 64'({prev_last, prev_data}));
      end
      if (exp_done) begin
        chk("done_after_sync", 64'(seq_done), 64'd1);
        exp_done = 1'b0;
      end
      chk("busy_eq_valid", 64'(busy), 64'(tx_valid));
      if (tx_valid && tx_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got %h expected none", tx_data);
        end else begin
          e = sbq.pop_front();
          chk("word", 64'({tx_last, tx_data}), 64'(e));
        end
        xfers++;
        if (tx_last && seq_enable) exp_done = 1'b1;
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_en    = seq_enable;
      prev_last  = tx_last;
      prev_data  = tx_data;
    end
  end

  task automatic run(input vec_t v);
    int x0;
    int cyc;
    int bcyc;
    x0 = xfers;
    push_seq(v.num, v.data);
    seq_num = v.num;
    seq_data = v.data;
    tx_ready = 1'b0;
    seq_enable = 1'b1;
    @(posedge clk); #1;
    chk("first_valid", 64'(tx_valid), 64'd1);
    cyc = 0;
    bcyc = 0;
    while (!seq_done && cyc < 1000) begin
      tx_ready = (cyc < 16) ? v.rpat[cyc] : 1'b1;
      @(negedge clk);
      if (busy) bcyc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_done", 64'(seq_done), 64'd1);
    chk("run_xfers", 64'(xfers - x0), 64'(v.exp_xfers));
    chk("run_busy_cycles", 64'(bcyc), 64'(v.exp_busy));
    chk("run_sb_empty", 64'(sbq.size()), 64'd0);
    chk("run_valid_low", 64'({tx_valid, tx_last, busy}), 64'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("done_held", 64'(seq_done), 64'd1);
    end
    seq_enable = 1'b0;
    @(posedge clk); #1;
    chk("done_cleared", 64'({seq_done, busy, tx_valid}), 64'd0);
    @(posedge clk); #1;
    sbq.delete();
  endtask

  task automatic wait_xfers(input int x0, input int n);
    int cyc;
    cyc = 0;
    while ((xfers - x0) < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("wait_xfers", 64'(xfers - x0), 64'(n));
  endtask

  initial begin
    int x0;
    int cyc;
    vecs[0] = '{8'd3,   32'h1234_5678, 16'hFFFF, 4,   4};
    vecs[1] = '{8'd0,   32'hDEAD_BEEF, 16'hFFFF, 1,   1};
    vecs[2] = '{8'd2,   32'hCAFE_0001, 16'hFFF2, 3,   6};
    vecs[3] = '{8'd1,   32'h0000_0001, 16'hFFFE, 2,   3};
    vecs[4] = '{8'd4,   32'h55AA_33CC, 16'h5555, 5,   9};
    vecs[5] = '{8'd255, 32'hFFFF_0000, 16'hFFFF, 256, 256};

    #1 rst = 1'b1;
    #2;
    chk("reset_outputs",
        64'({tx_valid, tx_last, seq_done, busy, tx_data}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_quiet", 64'({tx_valid, busy, seq_done}), 64'd0);

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Abort after four transfers: no done, IDLE next cycle.
    x0 = xfers;
    push_seq(8'd10, 32'h0F0F_1234);
    seq_num = 8'd10;
    seq_data = 32'h0F0F_1234;
    tx_ready = 1'b1;
    seq_enable = 1'b1;
    wait_xfers(x0, 4);
    seq_enable = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", 64'({tx_valid, tx_last, seq_done, busy}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'({seq_done, tx_valid}), 64'd0);
    end
    chk("abort_xfers", 64'(xfers - x0), 64'd4);
    sbq.delete();
    run('{8'd1, 32'h3141_5926, 16'hFFFF, 2, 2});

    // Async reset in the middle of SEND, then restart from word 0.
    x0 = xfers;
    push_seq(8'd5, 32'h0BAD_F00D);
    seq_num = 8'd5;
    seq_data = 32'h0BAD_F00D;
    tx_ready = 1'b1;
    seq_enable = 1'b1;
    wait_xfers(x0, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        64'({tx_valid, tx_last, seq_done, busy, tx_data}), 64'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_seq(8'd5, 32'h0BAD_F00D);
    x0 = xfers;
    cyc = 0;
    while (!seq_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("restart_done", 64'(seq_done), 64'd1);
    chk("restart_xfers", 64'(xfers - x0), 64'd6);
    chk("restart_sb_empty", 64'(sbq.size()), 64'd0);
    seq_enable = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    chk("restart_done_cleared", 64'(seq_done), 64'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
